// File: rtl/output_buffer.sv
// Purpose : receiver-side word FIFO plus byte unpacker; 32-bit words in, bytes out on valid/ready.
// Latency : push into an empty block gives byteValid=1 after the 2nd rising edge counting the push edge; 1 byte/cycle sustained.
// Backpr. : byteReady=0 holds byteOut/idx; words queue in the FIFO; push while full is dropped and sets sticky overflow.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   wordIn, push        word input and write strobe (one word per cycle)
//   full, overflow      FIFO holds DEPTH words / sticky "push seen while full"
//   level               words in the FIFO, excluding the word being unpacked
//   byteOut, byteValid  current byte and its valid flag
//   byteReady           sink accepts the byte when byteValid & byteReady
//   empty               FIFO empty and unpacker idle
module output_buffer #(
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [31:0]              wordIn,
   input  logic                     push,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               byteOut,
   output logic                     byteValid,
   input  logic                     byteReady,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_d;
   logic [31:0]   hold_q;
   logic [1:0]    idx_q;
   logic [1:0]    idx_d;
   logic [1:0]    byte_sel;
   state_t        state_q;
   state_t        state_d;
   logic          wr_en;
   logic          pop;
   logic          handshake;

   // full is the registered flag; a pop in the same cycle does not admit the push
   assign wr_en     = push & ~full;
   assign handshake = (state_q == SEND) & byteReady;

   always_comb begin
      level_d = level;
      case ({wr_en, pop})
         2'b10:   level_d = level + LW'(1);
         2'b01:   level_d = level - LW'(1);
         default: level_d = level;
      endcase
   end

   // FIFO storage carries no reset: level and the pointers define what is valid
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr] <= wordIn;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
         hold_q   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            hold_q <= mem[rd_ptr];
         end
         level <= level_d;
         full  <= (level_d == LW'(DEPTH));
         if (push && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Unpacker FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Unpacker FSM: next state; the last byte's handshake pops the next word with no bubble
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (level != '0) begin
               pop     = 1'b1;
               state_d = SEND;
               idx_d   = 2'd0;
            end
         end
         SEND: begin
            if (handshake) begin
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
               end else if (level != '0) begin
                  pop   = 1'b1;
                  idx_d = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Unpacker FSM: outputs; byte_sel maps idx to the byte lane of the held word
   always_comb begin
      byteValid = (state_q == SEND);
      empty     = (level == '0) && (state_q == IDLE);
      byte_sel  = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
      byteOut   = 8'h00;
      case (byte_sel)
         2'd0:    byteOut = hold_q[7:0];
         2'd1:    byteOut = hold_q[15:8];
         2'd2:    byteOut = hold_q[23:16];
         default: byteOut = hold_q[31:24];
      endcase
   end

endmodule

// File: tb/tb_output_buffer.sv
module tb_output_buffer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] wordIn;
   logic        push;
   logic        byteReady;

   logic        full,      full_l;
   logic        overflow,  overflow_l;
   logic [2:0]  level,     level_l;
   logic [7:0]  byteOut,   byteOut_l;
   logic        byteValid, byteValid_l;
   logic        empty,     empty_l;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   output_buffer #(.DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
      .clock(clock), .reset_n(reset_n), .wordIn(wordIn), .push(push),
      .full(full), .overflow(overflow), .level(level),
      .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady), .empty(empty)
   );

   output_buffer #(.DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clock(clock), .reset_n(reset_n), .wordIn(wordIn), .push(push),
      .full(full_l), .overflow(overflow_l), .level(level_l),
      .byteOut(byteOut_l), .byteValid(byteValid_l), .byteReady(byteReady), .empty(empty_l)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // advance one rising edge and settle away from it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [7:0]  t1_m [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0]  t1_l [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
   logic [7:0]  t2_b [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [31:0] w4   [6] = '{32'h00112233, 32'h44556677, 32'h8899AABB,
                             32'hCCDDEEFF, 32'h13579BDF, 32'h2468ACE0};
   logic        f4   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [2:0]  l4   [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
   logic [31:0] w5   [6] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4,
                             32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4};
   logic [7:0]  t5_m [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
   logic [7:0]  t5_l [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

   initial begin
      reset_n   = 1'b0;
      push      = 1'b0;
      wordIn    = 32'h0;
      byteReady = 1'b1;

      // reset state
      #2;
      chk("rst_vld",   32'(byteValid), 32'd0);
      chk("rst_byte",  32'(byteOut),   32'h00);
      chk("rst_full",  32'(full),      32'd0);
      chk("rst_ovf",   32'(overflow),  32'd0);
      chk("rst_level", 32'(level),     32'd0);
      chk("rst_empty", 32'(empty),     32'd1);
      step();
      step();
      reset_n = 1'b1;

      // 1: single word, latency, byte order on both instances
      wordIn = 32'h01020304;
      push   = 1'b1;
      step();
      push = 1'b0;
      chk("t1_vld_e0",   32'(byteValid), 32'd0);
      chk("t1_level_e0", 32'(level),     32'd1);
      chk("t1_empty_e0", 32'(empty),     32'd0);
      step();
      for (int b = 0; b < 4; b++) begin
         chk("t1_vld",    32'(byteValid),   32'd1);
         chk("t1_byte",   32'(byteOut),     32'(t1_m[b]));
         chk("t1_byte_l", 32'(byteOut_l),   32'(t1_l[b]));
         step();
      end
      chk("t1_vld_end",   32'(byteValid), 32'd0);
      chk("t1_empty_end", 32'(empty),     32'd1);

      // 2: two words back to back, no gap
      wordIn = 32'hAABBCCDD;
      push   = 1'b1;
      step();
      wordIn = 32'h11223344;
      step();
      push = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("t2_vld",  32'(byteValid), 32'd1);
         chk("t2_byte", 32'(byteOut),   32'(t2_b[k]));
         step();
      end
      chk("t2_vld_end", 32'(byteValid), 32'd0);

      // 3: stall mid-word
      wordIn = 32'hAABBCCDD;
      push   = 1'b1;
      step();
      push = 1'b0;
      step();
      chk("t3_first", 32'(byteOut), 32'hAA);
      step();
      byteReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_hold_byte", 32'(byteOut),   32'hBB);
         chk("t3_hold_vld",  32'(byteValid), 32'd1);
      end
      byteReady = 1'b1;
      step();
      chk("t3_cc", 32'(byteOut), 32'hCC);
      step();
      chk("t3_dd", 32'(byteOut), 32'hDD);
      step();
      chk("t3_vld_end", 32'(byteValid), 32'd0);

      // 4: fill past capacity; the first word moves into the unpacker, so
      //    four more fill the FIFO and the sixth is dropped
      byteReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wordIn = w4[i];
         push   = 1'b1;
         step();
         chk("t4_full",  32'(full),     32'(f4[i]));
         chk("t4_level", 32'(level),    32'(l4[i]));
         chk("t4_ovf",   32'(overflow), (i == 5) ? 32'd1 : 32'd0);
      end
      push      = 1'b0;
      byteReady = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [31:0] w;
         w = w4[k / 4];
         chk("t4_vld",  32'(byteValid), 32'd1);
         chk("t4_byte", 32'(byteOut),   32'(w[31 - 8 * (k % 4) -: 8]));
         step();
      end
      chk("t4_vld_end",   32'(byteValid), 32'd0);
      chk("t4_empty_end", 32'(empty),     32'd1);
      chk("t4_full_end",  32'(full),      32'd0);
      chk("t4_ovf_stick", 32'(overflow),  32'd1);

      // 5: second fill (pointers wrap again), then asynchronous reset mid-word
      byteReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wordIn = w5[i];
         push   = 1'b1;
         step();
      end
      push = 1'b0;
      chk("t5_full",  32'(full),     32'd1);
      chk("t5_level", 32'(level),    32'd4);
      chk("t5_first", 32'(byteOut),  32'hA1);
      byteReady = 1'b1;
      step();
      step();
      step();
      chk("t5_mid", 32'(byteOut), 32'hA4);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_vld",   32'(byteValid), 32'd0);
      chk("t5_rst_full",  32'(full),      32'd0);
      chk("t5_rst_ovf",   32'(overflow),  32'd0);
      chk("t5_rst_level", 32'(level),     32'd0);
      chk("t5_rst_empty", 32'(empty),     32'd1);
      step();
      step();
      reset_n = 1'b1;
      wordIn  = 32'hDEADBEEF;
      push    = 1'b1;
      step();
      push = 1'b0;
      chk("t5_new_vld_e0", 32'(byteValid), 32'd0);
      step();
      for (int b = 0; b < 4; b++) begin
         chk("t5_new_vld",    32'(byteValid), 32'd1);
         chk("t5_new_byte",   32'(byteOut),   32'(t5_m[b]));
         chk("t5_new_byte_l", 32'(byteOut_l), 32'(t5_l[b]));
         step();
      end
      chk("t5_vld_end",   32'(byteValid), 32'd0);
      chk("t5_empty_end", 32'(empty),     32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
